// File: rtl/gate_result_checker.sv
// rtl/gate_result_checker.sv - checks logic-gate block outputs against the ideal truth table over valid/ready runs (option: GATE_CHK_FIRST_FAIL_EN)
module gate_result_checker #(
    parameter int CNT_W   = 8,
    parameter int NUM_VEC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             a,
    input  logic             b,
    input  logic             out_not,
    input  logic             out_or,
    input  logic             out_and,
    input  logic             out_nand,
    input  logic             out_nor,
    input  logic             out_xor,
    input  logic             out_xnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [6:0]       fail_mask,
    output logic [1:0]       first_ab
);

    localparam int VC_W = $clog2(NUM_VEC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [VC_W-1:0]   vcnt_q, vcnt_d;
    logic              a_q, a_d, b_q, b_d;
    logic [6:0]        got_q, got_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [6:0]        mask_q, mask_d;
    logic [6:0]        exp_w;
    logic [6:0]        mism_w;
    logic              run_start_w;

    // Ideal gate outputs for the captured vector, in fail_mask bit order
    always_comb begin
        exp_w  = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                  a_q & b_q, a_q | b_q, ~a_q};
        mism_w = got_q ^ exp_w;
    end

    assign run_start_w = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state, capture and statistics update
    always_comb begin
        state_d = state_q;
        vcnt_d  = vcnt_q;
        a_d     = a_q;
        b_d     = b_q;
        got_d   = got_q;
        err_d   = err_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    vcnt_d  = '0;
                    err_d   = '0;
                    mask_d  = '0;
                end
            end
            S_RUN: begin
                if (vec_valid) begin
                    a_d     = a;
                    b_d     = b;
                    got_d   = {out_xnor, out_xor, out_nor, out_nand,
                               out_and, out_or, out_not};
                    vcnt_d  = vcnt_q + VC_W'(1);
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                mask_d = mask_q | mism_w;
                if ((|mism_w) && (err_q != {CNT_W{1'b1}})) begin
                    err_d = err_q + CNT_W'(1);
                end
                state_d = (vcnt_q == VC_W'(NUM_VEC)) ? S_DONE : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vcnt_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            got_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            got_q   <= got_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] first_q, first_d;

    // err_q still zero means this CMP is the first failing vector of the run
    always_comb begin
        first_d = first_q;
        if (run_start_w) begin
            first_d = 2'b00;
        end else if ((state_q == S_CMP) && (|mism_w) && (err_q == '0)) begin
            first_d = {a_q, b_q};
        end
    end

    // First-failing vector register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= 2'b00;
        end else begin
            first_q <= first_d;
        end
    end

    assign first_ab = first_q;
`else
    assign first_ab = 2'b00;
`endif

    assign vec_ready = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN) || (state_q == S_CMP);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_mask = mask_q;

    logic unused_w;
    assign unused_w = run_start_w;

endmodule
